fetch_stream_buffer: RTL

Parametrised fetch stage that replaces the tied-off fetch top. It streams line-aligned reads from instruction memory into a byte-granular prefetch queue. It presents up to OUTB contiguous instruction bytes plus their PC to decode, and pops exactly the number of bytes decode reports consumed. A `load` redirect restarts fetch at any byte address and discards all stale data, including responses still in flight.

---
 rtl/fetch_stream_buffer_if.sv | 30 +++
 rtl/fetch_stream_buffer.sv | 97 +++++++++
 2 files changed

// File: rtl/fetch_stream_buffer_if.sv
// fetch_stream_buffer_if: redirect, imem request/response and decode window signals of the fetch stage.
interface fetch_stream_buffer_if #(
    parameter int IDATAW = 64,
    parameter int IADDRW = 32,
    parameter int OUTB = 32,
    parameter int BW = $clog2(OUTB) + 1
);
    logic load;
    logic [IADDRW-1:0] load_address;
    logic imem_valid;
    logic imem_ready;
    logic [IADDRW-1:0] imem_address;
    logic imem_dp_valid;
    logic imem_dp_ready;
    logic [IDATAW-1:0] imem_dp_read_data;
    logic f_valid;
    logic f_ready;
    logic [BW-1:0] f_bytes_read;
    logic [BW-1:0] f_valid_bytes;
    logic [8*OUTB-1:0] f_instruction;
    logic [IADDRW-1:0] f_pc;
    modport slave (
        input load, load_address, imem_ready, imem_dp_valid, imem_dp_read_data, f_ready, f_bytes_read,
        output imem_valid, imem_address, imem_dp_ready, f_valid, f_valid_bytes, f_instruction, f_pc
    );
    modport master (
        output load, load_address, imem_ready, imem_dp_valid, imem_dp_read_data, f_ready, f_bytes_read,
        input imem_valid, imem_address, imem_dp_ready, f_valid, f_valid_bytes, f_instruction, f_pc
    );
endinterface

// File: rtl/fetch_stream_buffer.sv
// fetch_stream_buffer: streams line reads from imem into a byte queue and presents a decode window.
// A load redirect restarts fetch and discards queued bytes plus every response still in flight.
module fetch_stream_buffer #(
    parameter int IDATAW = 64,
    parameter int IADDRW = 32,
    parameter int DEPTH = 4,
    parameter int OUTB = 32,
    parameter int MAXOUT = 2
) (
    input logic clk,
    input logic reset,
    fetch_stream_buffer_if.slave bus
);
    localparam int LB = IDATAW / 8;
    localparam int LW = $clog2(LB);
    localparam int CAP = DEPTH * LB;
    localparam int CW = $clog2(CAP + 1);
    localparam int IW = $clog2(MAXOUT + 1);
    localparam int BW = $clog2(OUTB) + 1;

    logic [8*CAP-1:0] q_q, q_d;
    logic [CW-1:0] count_q, count_d;
    logic [IADDRW-1:0] pc_q, pc_d, fa_q, fa_d;
    logic [IW-1:0] inf_q, inf_d, drop_q, drop_d;
    logic [LW-1:0] skip_q, skip_d;
    logic run_q, run_d;
    logic hs, resp, take;
    int n, vb, pushed, base;

    always_comb vb = int'(count_q) < OUTB ? int'(count_q) : OUTB;

    // Space for every outstanding line is reserved before issuing, so responses never overflow.
    assign bus.imem_valid = run_q && int'(inf_q) < MAXOUT && int'(count_q) + (int'(inf_q) + 1) * LB <= CAP;
    assign bus.imem_address = fa_q;
    assign bus.imem_dp_ready = 1'b1;
    assign bus.f_valid = count_q != '0;
    assign bus.f_valid_bytes = BW'(vb);
    assign bus.f_pc = pc_q;

    always_comb begin
        bus.f_instruction = '0;
        for (int k = 0; k < OUTB && k < CAP; k++)
            if (k < vb) bus.f_instruction[k*8+:8] = q_q[k*8+:8];
    end

    always_comb begin
        hs = bus.imem_valid && bus.imem_ready;
        resp = bus.imem_dp_valid;
        take = resp && drop_q == '0;
        n = bus.f_valid && bus.f_ready ? (int'(bus.f_bytes_read) < vb ? int'(bus.f_bytes_read) : vb) : 0;
        pushed = take ? LB - int'(skip_q) : 0;
        base = int'(count_q) - n;
        q_d = '0;
        // Head stays at byte 0: survivors shift down by n, the new line lands right behind them.
        for (int i = 0; i < CAP; i++)
            q_d[i*8+:8] = i + n < int'(count_q) ? q_q[(i+n)*8+:8] :
                          (i >= base && i < base + pushed) ? bus.imem_dp_read_data[(int'(skip_q)+i-base)*8+:8] : 8'h00;
        count_d = CW'(base + pushed);
        pc_d = pc_q + IADDRW'(n);
        fa_d = hs ? fa_q + IADDRW'(LB) : fa_q;
        inf_d = IW'(int'(inf_q) + int'(hs) - int'(resp));
        drop_d = resp && drop_q != '0 ? drop_q - IW'(1) : drop_q;
        skip_d = take ? '0 : skip_q;
        run_d = run_q;
        if (bus.load) begin
            q_d = '0;
            count_d = '0;
            run_d = 1'b1;
            pc_d = bus.load_address;
            fa_d = {bus.load_address[IADDRW-1:LW], {LW{1'b0}}};
            skip_d = bus.load_address[LW-1:0];
            drop_d = inf_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
            count_q <= '0;
            pc_q <= '0;
            fa_q <= '0;
            inf_q <= '0;
            drop_q <= '0;
            skip_q <= '0;
            run_q <= 1'b0;
        end else begin
            q_q <= q_d;
            count_q <= count_d;
            pc_q <= pc_d;
            fa_q <= fa_d;
            inf_q <= inf_d;
            drop_q <= drop_d;
            skip_q <= skip_d;
            run_q <= run_d;
        end
    end
endmodule
